memory_game_controller: RTL and testbench

- Gameplay sequencer for the VGA memory-card game.
- Owns the cursor and the card state (face-up and matched), and runs the pick-two / show / compare cycle.
- Drives the masks and cursor that the renderer reads each pixel; reads the card values from the randomizer's `card_order`.
- Runs on the pixel clock; uses the renderer's start-of-vblank `frame` pulse as its timebase.

---
 rtl/memory_game_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_memory_game_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_controller.sv
// Gameplay sequencer for the memory-card game: cursor, face-up/matched masks, pick/show/compare cycle.
// Optional macro DEBOUNCE_EN adds frame-clocked button debouncing after the synchronizers.
module memory_game_controller #(
    parameter int COLS            = 5,
    parameter int ROWS            = 2,
    parameter int VAL_W           = 4,
    parameter int HOLD_FRAMES     = 60,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                        clock_25M,
    input  logic                        reset_n,
    input  logic                        frame,
    input  logic                        btn_select,
    input  logic                        btn_move_x,
    input  logic                        btn_move_y,
    input  logic [COLS*ROWS*VAL_W-1:0]  card_order,
    output logic [3:0]                  cursor_pos,
    output logic [COLS*ROWS-1:0]        face_up,
    output logic [COLS*ROWS-1:0]        matched,
    output logic [7:0]                  move_count,
    output logic [1:0]                  game_state,
    output logic                        new_game
);

    localparam int NUM_CARDS = COLS * ROWS;
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        S_PICK1 = 2'd0,
        S_PICK2 = 2'd1,
        S_SHOW  = 2'd2,
        S_WON   = 2'd3
    } state_t;

    // Button conditioning: bit 0 select, bit 1 move_x, bit 2 move_y
    logic [2:0] btn_raw;
    logic [2:0] btn_rise;

    assign btn_raw = {btn_move_y, btn_move_x, btn_select};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic level;
            logic level_prev_reg;

            always_ff @(posedge clock_25M or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

`ifdef DEBOUNCE_EN
            localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
            localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_FRAMES - 1);
            logic [DW-1:0] stable_cnt_reg;
            logic          deb_reg;

            // Level flips only after differing on DEBOUNCE_FRAMES consecutive frame pulses
            always_ff @(posedge clock_25M or negedge reset_n) begin
                if (!reset_n) begin
                    stable_cnt_reg <= '0;
                    deb_reg        <= 1'b0;
                end else if (frame) begin
                    if (sync2_reg != deb_reg) begin
                        if (stable_cnt_reg == DB_LAST) begin
                            deb_reg        <= sync2_reg;
                            stable_cnt_reg <= '0;
                        end else begin
                            stable_cnt_reg <= stable_cnt_reg + 1'b1;
                        end
                    end else begin
                        stable_cnt_reg <= '0;
                    end
                end
            end

            assign level = deb_reg;
`else
            assign level = sync2_reg;
`endif

            always_ff @(posedge clock_25M or negedge reset_n) begin
                if (!reset_n) begin
                    level_prev_reg <= 1'b0;
                end else begin
                    level_prev_reg <= level;
                end
            end

            assign btn_rise[gi] = level & ~level_prev_reg;
        end
    endgenerate

    logic [VAL_W-1:0] card_val [NUM_CARDS];

    generate
        for (gi = 0; gi < NUM_CARDS; gi++) begin : g_val
            assign card_val[gi] = card_order[gi*VAL_W +: VAL_W];
        end
    endgenerate

    state_t                 state_reg,      state_next;
    logic [CW-1:0]          col_reg,        col_next;
    logic [RW-1:0]          row_reg,        row_next;
    logic [NUM_CARDS-1:0]   face_up_reg,    face_up_next;
    logic [NUM_CARDS-1:0]   matched_reg,    matched_next;
    logic [7:0]             move_count_reg, move_count_next;
    logic [7:0]             hold_reg,       hold_next;
    logic [3:0]             first_reg,      first_next;
    logic [3:0]             second_reg,     second_next;
    logic                   new_game_reg,   new_game_next;

    logic       sel;
    logic       mv_x;
    logic       mv_y;
    logic       sel_valid;
    logic [7:0] hold_inc;

    assign sel       = btn_rise[0];
    assign mv_x      = btn_rise[1];
    assign mv_y      = btn_rise[2];
    assign sel_valid = sel & ~face_up_reg[cursor_pos] & ~matched_reg[cursor_pos];
    assign hold_inc  = hold_reg + 8'd1;

    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_PICK1;
            col_reg        <= '0;
            row_reg        <= '0;
            face_up_reg    <= '0;
            matched_reg    <= '0;
            move_count_reg <= '0;
            hold_reg       <= '0;
            first_reg      <= '0;
            second_reg     <= '0;
            new_game_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            face_up_reg    <= face_up_next;
            matched_reg    <= matched_next;
            move_count_reg <= move_count_next;
            hold_reg       <= hold_next;
            first_reg      <= first_next;
            second_reg     <= second_next;
            new_game_reg   <= new_game_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        face_up_next    = face_up_reg;
        matched_next    = matched_reg;
        move_count_next = move_count_reg;
        hold_next       = hold_reg;
        first_next      = first_reg;
        second_next     = second_reg;
        new_game_next   = 1'b0;

        // Moves use the current cursor; selects below also read the pre-move cursor
        if (state_reg != S_WON) begin
            if (mv_x) begin
                col_next = (col_reg == COL_LAST) ? '0 : col_reg + 1'b1;
            end
            if (mv_y) begin
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end
        end

        case (state_reg)
            S_PICK1: begin
                if (sel_valid) begin
                    face_up_next[cursor_pos] = 1'b1;
                    first_next               = cursor_pos;
                    state_next               = S_PICK2;
                end
            end
            S_PICK2: begin
                if (sel_valid) begin
                    face_up_next[cursor_pos] = 1'b1;
                    second_next              = cursor_pos;
                    hold_next                = '0;
                    state_next               = S_SHOW;
                end
            end
            S_SHOW: begin
                if (frame) begin
                    hold_next = hold_inc;
                    if (hold_inc == HOLD_LAST) begin
                        face_up_next[first_reg]  = 1'b0;
                        face_up_next[second_reg] = 1'b0;
                        if (move_count_reg != 8'hFF) begin
                            move_count_next = move_count_reg + 8'd1;
                        end
                        if (card_val[first_reg] == card_val[second_reg]) begin
                            matched_next[first_reg]  = 1'b1;
                            matched_next[second_reg] = 1'b1;
                        end
                        state_next = (&matched_next) ? S_WON : S_PICK1;
                    end
                end
            end
            S_WON: begin
                if (sel) begin
                    matched_next    = '0;
                    face_up_next    = '0;
                    move_count_next = '0;
                    col_next        = '0;
                    row_next        = '0;
                    new_game_next   = 1'b1;
                    state_next      = S_PICK1;
                end
            end
            default: state_next = S_PICK1;
        endcase
    end

    assign cursor_pos = 4'(row_reg) * 4'(COLS) + 4'(col_reg);
    assign face_up    = face_up_reg;
    assign matched    = matched_reg;
    assign move_count = move_count_reg;
    assign game_state = state_reg;
    assign new_game   = new_game_reg;

endmodule

// File: tb/tb_memory_game_controller.sv
// Bench for memory_game_controller: directed scenarios plus randomized play against a card-level model.
module tb_memory_game_controller;

    localparam int COLS = 5;
    localparam int ROWS = 2;
    localparam int NC   = COLS * ROWS;
    localparam int VW   = 4;
    localparam int HF   = 3;

    logic              clock_25M = 1'b0;
    logic              reset_n;
    logic              frame;
    logic              btn_select;
    logic              btn_move_x;
    logic              btn_move_y;
    logic [NC*VW-1:0]  card_order;
    logic [3:0]        cursor_pos;
    logic [NC-1:0]     face_up;
    logic [NC-1:0]     matched;
    logic [7:0]        move_count;
    logic [1:0]        game_state;
    logic              new_game;

    memory_game_controller #(
        .COLS(COLS), .ROWS(ROWS), .VAL_W(VW), .HOLD_FRAMES(HF), .DEBOUNCE_FRAMES(3)
    ) dut (
        .clock_25M  (clock_25M),
        .reset_n    (reset_n),
        .frame      (frame),
        .btn_select (btn_select),
        .btn_move_x (btn_move_x),
        .btn_move_y (btn_move_y),
        .card_order (card_order),
        .cursor_pos (cursor_pos),
        .face_up    (face_up),
        .matched    (matched),
        .move_count (move_count),
        .game_state (game_state),
        .new_game   (new_game)
    );

    always #20 clock_25M = ~clock_25M;

    int n_cmp = 0;
    int n_bad = 0;

    // Card-level model: cursor as (col,row), per-card flags, game phase 0..3
    int m_col, m_row, m_state, m_moves, m_hold, m_first, m_second;
    int m_fu [NC];
    int m_mt [NC];
    int vals [NC];

    function automatic void m_reset();
        m_col = 0; m_row = 0; m_state = 0; m_moves = 0;
        m_hold = 0; m_first = 0; m_second = 0;
        for (int i = 0; i < NC; i++) begin
            m_fu[i] = 0;
            m_mt[i] = 0;
        end
    endfunction

    function automatic void m_action(input int s, input int mx, input int my);
        int pos;
        pos = m_row * COLS + m_col;
        if (m_state == 3) begin
            if (s != 0) begin
                for (int i = 0; i < NC; i++) begin
                    m_fu[i] = 0;
                    m_mt[i] = 0;
                end
                m_col = 0; m_row = 0; m_moves = 0; m_state = 0;
            end
            return;
        end
        if (s != 0 && m_fu[pos] == 0 && m_mt[pos] == 0) begin
            if (m_state == 0) begin
                m_fu[pos] = 1; m_first = pos; m_state = 1;
            end else if (m_state == 1) begin
                m_fu[pos] = 1; m_second = pos; m_hold = 0; m_state = 2;
            end
        end
        if (mx != 0) m_col = (m_col + 1) % COLS;
        if (my != 0) m_row = (m_row + 1) % ROWS;
    endfunction

    function automatic void m_frame();
        int all;
        if (m_state != 2) return;
        m_hold++;
        if (m_hold == HF) begin
            m_fu[m_first]  = 0;
            m_fu[m_second] = 0;
            if (m_moves < 255) m_moves++;
            if (vals[m_first] == vals[m_second]) begin
                m_mt[m_first]  = 1;
                m_mt[m_second] = 1;
            end
            all = 1;
            for (int i = 0; i < NC; i++) if (m_mt[i] == 0) all = 0;
            m_state = (all != 0) ? 3 : 0;
        end
    endfunction

    function automatic logic [NC-1:0] m_fu_vec();
        logic [NC-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i] = (m_fu[i] != 0);
        return v;
    endfunction

    function automatic logic [NC-1:0] m_mt_vec();
        logic [NC-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i] = (m_mt[i] != 0);
        return v;
    endfunction

    function automatic void load_cards();
        for (int i = 0; i < NC; i++) card_order[i*VW +: VW] = 4'(vals[i]);
    endfunction

    task automatic press(input int s, input int mx, input int my);
        btn_select = (s != 0);
        btn_move_x = (mx != 0);
        btn_move_y = (my != 0);
        repeat (4) @(negedge clock_25M);
        btn_select = 1'b0;
        btn_move_x = 1'b0;
        btn_move_y = 1'b0;
        repeat (4) @(negedge clock_25M);
        m_action(s, mx, my);
        $display("press sel=%0d mx=%0d my=%0d -> cursor=%0d state=%0d face_up=%h matched=%h moves=%0d",
                 s, mx, my, cursor_pos, game_state, face_up, matched, move_count);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clock_25M);
        frame = 1'b0;
        @(negedge clock_25M);
        m_frame();
        $display("frame -> state=%0d face_up=%h matched=%h moves=%0d",
                 game_state, face_up, matched, move_count);
    endtask

    task automatic do_reset();
        @(negedge clock_25M);
        reset_n = 1'b0;
        repeat (2) @(negedge clock_25M);
        reset_n = 1'b1;
        @(negedge clock_25M);
        m_reset();
    endtask

    task automatic goto_pos(input int p);
        while (m_col != p % COLS) press(0, 1, 0);
        while (m_row != p / COLS) press(0, 0, 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NC; i++) vals[i] = i % 5;
        load_cards();
        press(0, 1, 0);
        press(1, 0, 0);
        // assert reset between clock edges; outputs must clear without a clock
        #7 reset_n = 1'b0;
        #1;
        n_cmp++; if (cursor_pos !== 4'd0) begin n_bad++; $display("FAIL reset cursor got %0d want 0", cursor_pos); end
        n_cmp++; if (face_up !== '0) begin n_bad++; $display("FAIL reset face_up got %h want 0", face_up); end
        n_cmp++; if (matched !== '0) begin n_bad++; $display("FAIL reset matched got %h want 0", matched); end
        n_cmp++; if (move_count !== 8'd0) begin n_bad++; $display("FAIL reset moves got %0d want 0", move_count); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL reset state got %0d want 0", game_state); end
        n_cmp++; if (new_game !== 1'b0) begin n_bad++; $display("FAIL reset new_game got %0d want 0", new_game); end
        @(negedge clock_25M);
        reset_n = 1'b1;
        @(negedge clock_25M);
        m_reset();
    endtask

    task automatic test_cursor_wrap();
        int exp_pos [8] = '{1, 2, 3, 4, 0, 5, 0, 6};
        int mx_tab  [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
        int my_tab  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            press(0, mx_tab[i], my_tab[i]);
            n_cmp++;
            if (cursor_pos !== 4'(exp_pos[i])) begin
                n_bad++;
                $display("FAIL cursor_wrap step %0d got %0d want %0d", i, cursor_pos, exp_pos[i]);
            end
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        n_cmp++; if (face_up !== 10'h003) begin n_bad++; $display("FAIL mismatch face_up got %h want 003", face_up); end
        n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("FAIL mismatch state got %0d want 2", game_state); end
        pulse_frame();
        pulse_frame();
        n_cmp++; if (face_up !== 10'h003) begin n_bad++; $display("FAIL mismatch hold face_up got %h want 003", face_up); end
        n_cmp++; if (move_count !== 8'd0) begin n_bad++; $display("FAIL mismatch hold moves got %0d want 0", move_count); end
        pulse_frame();
        n_cmp++; if (face_up !== 10'h000) begin n_bad++; $display("FAIL mismatch face_up after got %h want 000", face_up); end
        n_cmp++; if (matched !== 10'h000) begin n_bad++; $display("FAIL mismatch matched got %h want 000", matched); end
        n_cmp++; if (move_count !== 8'd1) begin n_bad++; $display("FAIL mismatch moves got %0d want 1", move_count); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL mismatch state after got %0d want 0", game_state); end
    endtask

    task automatic test_match_ignored();
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("FAIL reselect state got %0d want 1", game_state); end
        n_cmp++; if (face_up !== 10'h001) begin n_bad++; $display("FAIL reselect face_up got %h want 001", face_up); end
        press(0, 0, 1);
        press(1, 0, 0);
        n_cmp++; if (face_up !== 10'h021) begin n_bad++; $display("FAIL match face_up got %h want 021", face_up); end
        repeat (HF) pulse_frame();
        n_cmp++; if (matched !== 10'h021) begin n_bad++; $display("FAIL match matched got %h want 021", matched); end
        n_cmp++; if (move_count !== 8'd1) begin n_bad++; $display("FAIL match moves got %0d want 1", move_count); end
        press(1, 0, 0);
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL matched-select state got %0d want 0", game_state); end
        n_cmp++; if (face_up !== 10'h000) begin n_bad++; $display("FAIL matched-select face_up got %h want 000", face_up); end
    endtask

    task automatic test_win_restart();
        int ng_count;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            goto_pos(p);
            press(1, 0, 0);
            press(0, 0, 1);
            press(1, 0, 0);
            repeat (HF) pulse_frame();
        end
        n_cmp++; if (matched !== 10'h3FF) begin n_bad++; $display("FAIL win matched got %h want 3ff", matched); end
        n_cmp++; if (game_state !== 2'd3) begin n_bad++; $display("FAIL win state got %0d want 3", game_state); end
        n_cmp++; if (move_count !== 8'd5) begin n_bad++; $display("FAIL win moves got %0d want 5", move_count); end
        press(0, 1, 1);
        n_cmp++; if (cursor_pos !== 4'd9) begin n_bad++; $display("FAIL won-move cursor got %0d want 9", cursor_pos); end
        ng_count = 0;
        btn_select = 1'b1;
        repeat (10) begin
            @(negedge clock_25M);
            if (new_game === 1'b1) ng_count++;
        end
        btn_select = 1'b0;
        repeat (4) @(negedge clock_25M);
        m_action(1, 0, 0);
        n_cmp++; if (ng_count != 1) begin n_bad++; $display("FAIL new_game cycles got %0d want 1", ng_count); end
        n_cmp++; if (matched !== 10'h000) begin n_bad++; $display("FAIL restart matched got %h want 000", matched); end
        n_cmp++; if (move_count !== 8'd0) begin n_bad++; $display("FAIL restart moves got %0d want 0", move_count); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL restart state got %0d want 0", game_state); end
        n_cmp++; if (cursor_pos !== 4'd0) begin n_bad++; $display("FAIL restart cursor got %0d want 0", cursor_pos); end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        pulse_frame();
        do_reset();
        n_cmp++; if (face_up !== 10'h000) begin n_bad++; $display("FAIL midshow face_up got %h want 000", face_up); end
        n_cmp++; if (move_count !== 8'd0) begin n_bad++; $display("FAIL midshow moves got %0d want 0", move_count); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL midshow state got %0d want 0", game_state); end
        repeat (HF) pulse_frame();
        n_cmp++; if (move_count !== 8'd0) begin n_bad++; $display("FAIL midshow late moves got %0d want 0", move_count); end
        n_cmp++; if (matched !== 10'h000) begin n_bad++; $display("FAIL midshow late matched got %h want 000", matched); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NC; i++) vals[i] = i;
        load_cards();
        do_reset();
        for (int a = 0; a < 257; a++) begin
            press(1, 0, 0);
            press(0, 1, 0);
            press(1, 0, 0);
            repeat (HF) pulse_frame();
        end
        n_cmp++; if (move_count !== 8'(m_moves)) begin n_bad++; $display("FAIL saturation model got %0d want %0d", move_count, m_moves); end
        n_cmp++; if (move_count !== 8'd255) begin n_bad++; $display("FAIL saturation got %0d want 255", move_count); end
    endtask

    task automatic test_random();
        int t, j, r;
        for (int i = 0; i < NC; i++) vals[i] = i % 5;
        for (int i = NC - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        load_cards();
        do_reset();
        for (int step = 0; step < 400; step++) begin
            r = $urandom_range(9, 0);
            if (r < 4) pulse_frame();
            else press(($urandom_range(2, 0) == 0) ? 0 : 1, $urandom_range(1, 0), $urandom_range(1, 0));
            n_cmp++; if (cursor_pos !== 4'(m_row * COLS + m_col)) begin n_bad++; $display("FAIL random[%0d] cursor got %0d want %0d", step, cursor_pos, m_row * COLS + m_col); end
            n_cmp++; if (face_up !== m_fu_vec()) begin n_bad++; $display("FAIL random[%0d] face_up got %h want %h", step, face_up, m_fu_vec()); end
            n_cmp++; if (matched !== m_mt_vec()) begin n_bad++; $display("FAIL random[%0d] matched got %h want %h", step, matched, m_mt_vec()); end
            n_cmp++; if (move_count !== 8'(m_moves)) begin n_bad++; $display("FAIL random[%0d] moves got %0d want %0d", step, move_count, m_moves); end
            n_cmp++; if (game_state !== 2'(m_state)) begin n_bad++; $display("FAIL random[%0d] state got %0d want %0d", step, game_state, m_state); end
            n_cmp++; if (new_game !== 1'b0) begin n_bad++; $display("FAIL random[%0d] new_game got %0d want 0", step, new_game); end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        frame      = 1'b0;
        btn_select = 1'b0;
        btn_move_x = 1'b0;
        btn_move_y = 1'b0;
        card_order = '0;
        m_reset();
        repeat (3) @(negedge clock_25M);
        reset_n = 1'b1;
        @(negedge clock_25M);

        test_reset();
        test_cursor_wrap();
        test_mismatch();
        test_match_ignored();
        test_win_restart();
        test_reset_mid_show();
        test_random();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
